// File: rtl/csi_pckt_gen.sv
// ---------------------------------------------------------------------------
// csi_pckt_gen -- CSI-2 packet generator (transmit side of the packet-handler
// interface). Turns a frame request plus a streamed pixel payload into
//   SOF short packet, one RAW long packet per line, EOF short packet,
// each followed by GAP_CYCLES idle cycles. All link outputs are registered.
//
// Optional build macro: CSI_PCKT_GEN_CRC_EN
//   defined   -> one CRC-16 word follows every line payload
//   undefined -> the gap follows the last payload word directly
//
// Ports:
//   rxbyteclkhs      in   byte clock, all logic on its rising edge
//   reset            in   asynchronous active-high reset
//   frame_start      in   request one frame (sampled in IDLE only)
//   lines_per_frame  in   line packets per frame (latched at accept)
//   word_count       in   line payload bytes (latched at accept)
//   inject_ecc_err   in   flag the first line header of the frame
//   in_data/in_valid in   payload word stream (low byte first on the link)
//   in_ready         out  generator takes in_data this cycle
//   data_stream      out  payload / CRC word
//   ph_stream        out  packet header {WC_MSB, WC_LSB, DATA_ID}
//   ph_select        out  header cycle
//   valid_stream     out  link active
//   ecc_error        out  header carries an injected ECC error
//   busy             out  frame in progress
//   frame_done       out  pulse with the EOF header
//   underrun         out  pulse with each zero-filled payload word
// ---------------------------------------------------------------------------
module csi_pckt_gen #(
    parameter int          DATA_STREAM_WIDTH = 16,
    parameter int          PH_STREAM_WIDTH   = 24,
    parameter logic [5:0]  DATA_TYPE         = 6'h2B,
    parameter logic [1:0]  VC                = 2'd0,
    parameter int          GAP_CYCLES        = 4
) (
    input  logic                         rxbyteclkhs,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [31:0]                  lines_per_frame,
    input  logic [15:0]                  word_count,
    input  logic                         inject_ecc_err,
    input  logic [DATA_STREAM_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_STREAM_WIDTH-1:0] data_stream,
    output logic [PH_STREAM_WIDTH-1:0]   ph_stream,
    output logic                         ph_select,
    output logic                         valid_stream,
    output logic                         ecc_error,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         underrun
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

`ifdef CSI_PCKT_GEN_CRC_EN
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_LINE_PH, S_PAYLOAD, S_CRC, S_EOF, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_LINE_PH, S_PAYLOAD, S_EOF, S_GAP} state_t;
`endif

    state_t                         state_q;
    logic [31:0]                    lines_q;
    logic [15:0]                    wc_q;
    logic [15:0]                    nwords_q;      // ceil(word_count/2)
    logic                           ecc_inj_q;
    logic [31:0]                    line_cnt_q;
    logic [15:0]                    words_left_q;  // words still to send in PAYLOAD
    logic [GW-1:0]                  gap_cnt_q;
    logic [15:0]                    frame_num_q;
    logic                           eof_sent_q;    // gap after EOF returns to IDLE

    logic                           in_ready_q;
    logic [DATA_STREAM_WIDTH-1:0]   data_q;
    logic [PH_STREAM_WIDTH-1:0]     ph_q;
    logic                           ph_select_q;
    logic                           valid_q;
    logic                           ecc_q;
    logic                           busy_q;
    logic                           frame_done_q;
    logic                           underrun_q;

    logic [15:0]                    nwords_in;
    logic [15:0]                    words_rem;
    logic [DATA_STREAM_WIDTH-1:0]   word_out;

    assign nwords_in = {1'b0, word_count[15:1]} + {15'd0, word_count[0]};

    // The word taken on the edge leaving LINE_PH is the first one, so the
    // remaining count comes from the latched total while in LINE_PH.
    assign words_rem = (state_q == S_LINE_PH) ? nwords_q : words_left_q;

    // The link cannot stall: a missing input word is sent as zero.
    assign word_out  = in_valid ? in_data : '0;

`ifdef CSI_PCKT_GEN_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_lo;
    logic [15:0] crc_next;

    // Reflected CRC-16 (x^16+x^12+x^5+1), bits LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // The padding byte of an odd-length line is not payload, so it is left
    // out of the checksum.
    assign crc_lo   = crc16_byte(crc_q, word_out[7:0]);
    assign crc_next = (words_rem == 16'd1 && wc_q[0]) ? crc_lo
                                                     : crc16_byte(crc_lo, word_out[15:8]);
`endif

    always_ff @(posedge rxbyteclkhs or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lines_q      <= '0;
            wc_q         <= '0;
            nwords_q     <= '0;
            ecc_inj_q    <= 1'b0;
            line_cnt_q   <= '0;
            words_left_q <= '0;
            gap_cnt_q    <= '0;
            frame_num_q  <= 16'd1;
            eof_sent_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            data_q       <= '0;
            ph_q         <= '0;
            ph_select_q  <= 1'b0;
            valid_q      <= 1'b0;
            ecc_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef CSI_PCKT_GEN_CRC_EN
            crc_q        <= 16'hFFFF;
`endif
        end else begin
            // Link outputs default to idle; each state sets what it drives.
            in_ready_q   <= 1'b0;
            data_q       <= '0;
            ph_q         <= '0;
            ph_select_q  <= 1'b0;
            valid_q      <= 1'b0;
            ecc_q        <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        lines_q     <= lines_per_frame;
                        wc_q        <= word_count;
                        nwords_q    <= nwords_in;
                        ecc_inj_q   <= inject_ecc_err;
                        line_cnt_q  <= '0;
                        eof_sent_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SOF;
                        valid_q     <= 1'b1;
                        ph_select_q <= 1'b1;
                        ph_q        <= {frame_num_q, VC, 6'h00};
                    end
                end

                S_SOF: begin
                    state_q   <= S_GAP;
                    gap_cnt_q <= GAP_LAST;
                end

                S_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end else if (eof_sent_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (line_cnt_q == lines_q) begin
                        state_q      <= S_EOF;
                        eof_sent_q   <= 1'b1;
                        valid_q      <= 1'b1;
                        ph_select_q  <= 1'b1;
                        ph_q         <= {frame_num_q, VC, 6'h01};
                        frame_done_q <= 1'b1;
                    end else begin
                        state_q      <= S_LINE_PH;
                        line_cnt_q   <= line_cnt_q + 32'd1;
                        words_left_q <= nwords_q;
                        valid_q      <= 1'b1;
                        ph_select_q  <= 1'b1;
                        ph_q         <= {wc_q, VC, DATA_TYPE};
                        ecc_q        <= ecc_inj_q && (line_cnt_q == '0);
                        in_ready_q   <= (nwords_q != '0);
`ifdef CSI_PCKT_GEN_CRC_EN
                        crc_q        <= 16'hFFFF;
`endif
                    end
                end

                S_LINE_PH, S_PAYLOAD: begin
                    if (words_rem == '0) begin
`ifdef CSI_PCKT_GEN_CRC_EN
                        state_q <= S_CRC;
                        valid_q <= 1'b1;
                        data_q  <= crc_q;
`else
                        state_q   <= S_GAP;
                        gap_cnt_q <= GAP_LAST;
`endif
                    end else begin
                        state_q      <= S_PAYLOAD;
                        valid_q      <= 1'b1;
                        data_q       <= word_out;
                        underrun_q   <= ~in_valid;
                        words_left_q <= words_rem - 16'd1;
                        in_ready_q   <= (words_rem > 16'd1);
`ifdef CSI_PCKT_GEN_CRC_EN
                        crc_q        <= crc_next;
`endif
                    end
                end

`ifdef CSI_PCKT_GEN_CRC_EN
                S_CRC: begin
                    state_q   <= S_GAP;
                    gap_cnt_q <= GAP_LAST;
                end
`endif

                S_EOF: begin
                    // Frame number 0 is reserved, so the counter wraps to 1.
                    frame_num_q <= (frame_num_q == 16'hFFFF) ? 16'd1 : frame_num_q + 16'd1;
                    state_q     <= S_GAP;
                    gap_cnt_q   <= GAP_LAST;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign data_stream  = data_q;
    assign ph_stream    = ph_q;
    assign ph_select    = ph_select_q;
    assign valid_stream = valid_q;
    assign ecc_error    = ecc_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_csi_pckt_gen.sv
`timescale 1ns/1ps
module tb_csi_pckt_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [31:0] lines_per_frame;
    logic [15:0] word_count;
    logic        inject_ecc_err;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_stream;
    logic [23:0] ph_stream;
    logic        ph_select;
    logic        valid_stream;
    logic        ecc_error;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] src_words [0:15];
    bit          src_valid [0:15];
    int          src_idx = 0;

    csi_pckt_gen dut (
        .rxbyteclkhs     (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .lines_per_frame (lines_per_frame),
        .word_count      (word_count),
        .inject_ecc_err  (inject_ecc_err),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .data_stream     (data_stream),
        .ph_stream       (ph_stream),
        .ph_select       (ph_select),
        .valid_stream    (valid_stream),
        .ecc_error       (ecc_error),
        .busy            (busy),
        .frame_done      (frame_done),
        .underrun        (underrun)
    );

    always #5 clk = ~clk;

    // Payload source: presents the next table word whenever the generator
    // is ready; the word is consumed on the following rising edge.
    always @(negedge clk) begin
        if (in_ready) begin
            in_data  = src_words[src_idx];
            in_valid = src_valid[src_idx];
            src_idx  = src_idx + 1;
        end else begin
            in_data  = 16'hDEAD;
            in_valid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference CRC: xor the byte in, then eight reflected shifts.
    function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    task automatic check_gap(input string tag);
        repeat (4) begin
            @(negedge clk);
            check({tag, ":gap_valid"}, valid_stream, 0);
            check({tag, ":gap_sel"},   ph_select, 0);
            check({tag, ":gap_ph"},    ph_stream, 0);
            check({tag, ":gap_data"},  data_stream, 0);
        end
    endtask

    // Requests one frame at the current (IDLE) negedge and checks every link
    // cycle through the return to IDLE.
    task automatic run_frame(input string tag, input logic [15:0] fnum, input int lines,
                             input int wc, input bit ecc, input bit hold);
        int n;
        int idx;
        logic [15:0] w;
        logic [15:0] crc;
        n   = (wc + 1) / 2;
        idx = 0;
        lines_per_frame = lines;
        word_count      = wc[15:0];
        inject_ecc_err  = ecc;
        src_idx         = 0;
        frame_start     = 1'b1;
        @(negedge clk);
        if (!hold) frame_start = 1'b0;
        check({tag, ":sof_ph"},    ph_stream, {fnum, 8'h00});
        check({tag, ":sof_sel"},   ph_select, 1);
        check({tag, ":sof_valid"}, valid_stream, 1);
        check({tag, ":sof_busy"},  busy, 1);
        check({tag, ":sof_done"},  frame_done, 0);
        check_gap(tag);
        for (int l = 0; l < lines; l++) begin
            @(negedge clk);
            check({tag, ":lph_ph"},    ph_stream, {wc[15:0], 8'h2B});
            check({tag, ":lph_sel"},   ph_select, 1);
            check({tag, ":lph_valid"}, valid_stream, 1);
            check({tag, ":lph_ecc"},   ecc_error, (ecc && l == 0) ? 1 : 0);
            check({tag, ":lph_ready"}, in_ready, (n > 0) ? 1 : 0);
            crc = 16'hFFFF;
            for (int k = 1; k <= n; k++) begin
                @(negedge clk);
                w = src_valid[idx] ? src_words[idx] : 16'h0000;
                check({tag, ":pl_data"},  data_stream, w);
                check({tag, ":pl_under"}, underrun, src_valid[idx] ? 0 : 1);
                check({tag, ":pl_ready"}, in_ready, (k < n) ? 1 : 0);
                check({tag, ":pl_sel"},   ph_select, 0);
                check({tag, ":pl_valid"}, valid_stream, 1);
                crc = ref_crc(crc, w[7:0]);
                if (!(k == n && wc % 2 == 1)) crc = ref_crc(crc, w[15:8]);
                idx++;
            end
`ifdef CSI_PCKT_GEN_CRC_EN
            @(negedge clk);
            check({tag, ":crc"},       data_stream, crc);
            check({tag, ":crc_valid"}, valid_stream, 1);
            check({tag, ":crc_sel"},   ph_select, 0);
`endif
            check_gap(tag);
        end
        @(negedge clk);
        frame_start = 1'b0;
        check({tag, ":eof_ph"},   ph_stream, {fnum, 8'h01});
        check({tag, ":eof_sel"},  ph_select, 1);
        check({tag, ":eof_done"}, frame_done, 1);
        check_gap(tag);
        check({tag, ":gap_busy"}, busy, 1);
        @(negedge clk);
        check({tag, ":end_busy"},  busy, 0);
        check({tag, ":end_valid"}, valid_stream, 0);
        $display("[TB] frame %s fnum=%h lines=%0d wc=%0d checked", tag, fnum, lines, wc);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; lines_per_frame = '0; word_count = '0;
        inject_ecc_err = 1'b0; in_data = '0; in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin src_words[i] = 16'h0; src_valid[i] = 1'b1; end
        repeat (3) @(negedge clk);
        check("rst:valid", valid_stream, 0);
        check("rst:ph",    ph_stream, 0);
        check("rst:data",  data_stream, 0);
        check("rst:busy",  busy, 0);
        check("rst:ready", in_ready, 0);
        check("rst:done",  frame_done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Two lines of 4 bytes
        src_words[0] = 16'h0A0B; src_words[1] = 16'h0C0D;
        src_words[2] = 16'h0A0B; src_words[3] = 16'h0C0D;
        run_frame("basic", 16'd1, 2, 4, 1'b0, 1'b0);

        // Odd byte count, frame_start held through the frame
        src_words[0] = 16'h1111; src_words[1] = 16'h2222; src_words[2] = 16'h3333;
        run_frame("odd_hold", 16'd2, 1, 5, 1'b0, 1'b1);

        // Missing input on the second word
        src_words[0] = 16'h4455; src_words[1] = 16'h6677; src_words[2] = 16'h8899;
        src_valid[1] = 1'b0;
        run_frame("underrun", 16'd3, 1, 6, 1'b0, 1'b0);
        src_valid[1] = 1'b1;

        // "1234"
        src_words[0] = 16'h3231; src_words[1] = 16'h3433;
        run_frame("ascii", 16'd4, 1, 4, 1'b0, 1'b0);

        // Frame number wrap
        force dut.frame_num_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_num_q;
        run_frame("zero_lines", 16'hFFFF, 0, 4, 1'b0, 1'b0);

        src_words[0] = 16'hBEEF; src_words[1] = 16'hCAFE;
        run_frame("ecc", 16'd1, 2, 2, 1'b1, 1'b0);

        // Reset in the middle of a payload
        lines_per_frame = 1; word_count = 8; inject_ecc_err = 1'b0; src_idx = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid:in_payload", valid_stream, 1);
        reset = 1'b1;
        #1;
        check("mid:valid", valid_stream, 0);
        check("mid:data",  data_stream, 0);
        check("mid:busy",  busy, 0);
        check("mid:ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        src_words[0] = 16'h0102; src_words[1] = 16'h0304;
        run_frame("after_rst", 16'd1, 1, 4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/csi_pckt_gen.md
Name: csi_pckt_gen

Overview:
- CSI-2 packet generator: the transmit end of the packet-handler interface.
- Turns a frame request plus a streamed pixel payload into the header/payload/gap sequence the packet handler consumes: SOF short packet, one RAW long packet per line, EOF short packet.
- Drives data_stream, ph_stream, ph_select, valid_stream and ecc_error directly. Used as the on-chip source for loopback and pattern tests.

Parameters:
- DATA_STREAM_WIDTH, 16, payload word width; fixed at two bytes per cycle.
- PH_STREAM_WIDTH, 24, packet header width {WC_MSB, WC_LSB, DATA_ID}.
- DATA_TYPE, 6'h2B, data type of line packets (RAW10).
- VC, 2'd0, virtual channel placed in DATA_ID[7:6] of every header.
- GAP_CYCLES, 4, idle cycles after every packet (valid_stream low); legal minimum 2.

Ports:
- rxbyteclkhs  in  1  byte clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  request one frame; sampled only in IDLE
- lines_per_frame  in  32  line packets per frame; latched at accept
- word_count  in  16  line payload size in bytes; latched at accept
- inject_ecc_err  in  1  latched at accept; flags first line header of the frame
- in_data  in  DATA_STREAM_WIDTH  payload word (low byte first on the link)
- in_valid  in  1  in_data valid
- in_ready  out  1  generator takes in_data this cycle
- data_stream  out  DATA_STREAM_WIDTH  payload word to the link
- ph_stream  out  PH_STREAM_WIDTH  packet header
- ph_select  out  1  high on header cycles
- valid_stream  out  1  link active (SoT..EoT)
- ecc_error  out  1  high with a header carrying an injected ECC error
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse with the EOF header
- underrun  out  1  one-cycle pulse with each zero-filled payload word

Behaviour:
- Reset: all outputs 0; state IDLE; frame_num = 16'd1; latched registers 0. Asserting reset mid-frame drops valid_stream immediately; no EOF is sent.
- All link outputs are registered.
- data_stream is 0 outside payload/CRC cycles. ph_stream is 0 outside header cycles.
- States: IDLE, SOF, LINE_PH, PAYLOAD, CRC (macro only), EOF, GAP.
- IDLE: frame_start high at cycle T → latch inputs, busy=1 from T+1, SOF header on the outputs at T+1.
- SOF: one cycle.
  - valid_stream=1, ph_select=1, ph_stream={frame_num, VC, 6'h00}.
  - Then GAP, returning to LINE_PH, or to EOF if lines_per_frame==0.
- LINE_PH (cycle H): valid_stream=1, ph_select=1, ph_stream={word_count, VC, DATA_TYPE}. ecc_error=1 only on the first line of a frame latched with inject_ecc_err.
- PAYLOAD: N = ceil(word_count/2) cycles H+1..H+N.
  - valid_stream=1, ph_select=0.
  - in_ready=1 during cycles H..H+N-1; the word sampled at cycle H+k-1 appears on data_stream at H+k.
  - If in_valid=0 on a ready cycle: that output word is 0, underrun pulses with it, the count still advances (the link cannot stall).
  - word_count==0: N=0, no payload, in_ready never asserted.
  - Odd word_count: the upper byte of the last word is don't-care, driven from in_data.
- After the last payload cycle: GAP, then the next LINE_PH, or EOF once the line counter reaches lines_per_frame.
- Line counter: 32-bit, cleared at accept, increments at each LINE_PH.
- EOF: one cycle.
  - valid_stream=1, ph_select=1, ph_stream={frame_num, VC, 6'h01}, frame_done=1.
  - Then GAP → IDLE. busy drops on the IDLE entry cycle.
  - frame_num increments after EOF; 16'hFFFF wraps to 16'd1 (0 never used).
- GAP: exactly GAP_CYCLES cycles with valid_stream=0 and ph_select=0.
- in_ready is 0 in every state except as defined under PAYLOAD.
- frame_start while busy: ignored, with no queuing.

Optional Feature:
- Macro CSI_PCKT_GEN_CRC_EN.
- Defined: after PAYLOAD (including N=0), one CRC cycle with valid_stream=1, ph_select=0 and data_stream = CRC-16 of the payload bytes.
  - Polynomial x^16+x^12+x^5+1, init 16'hFFFF, bytes LSB-first, low byte of each word before the high byte.
  - Zero-filled words are included as sent.
  - N=0 gives 16'hFFFF.
- Undefined: no CRC state; GAP follows the last payload word directly.

Test Plan:
- Reset, lines_per_frame=2, word_count=4, in_valid=1, in_data=16'h0A0B then 16'h0C0D: ph_stream 24'h000100 (SOF, 1 cycle), 4 idle, 24'h00042B, 16'h0A0B, 16'h0C0D, 4 idle, line 2 repeats, 24'h000101 with frame_done, busy drops after the final gap.
- word_count=5, 1 line: 3 payload cycles, in_ready high exactly 3 cycles starting with the header cycle.
- in_valid low on the 2nd payload word: data_stream 16'h0000 and underrun for that cycle only; EOF timing unchanged.
- Two back-to-back frames: SOF WCs 1 then 2; frame_num forced to 16'hFFFF: next SOF WC = 16'h0001. frame_start held during frame 1 does not start an extra frame.
- lines_per_frame=0: SOF, 4 idle, EOF; no line header, in_ready never high. inject_ecc_err=1 with 1 line: ecc_error high on that line header only.
- Reset mid-payload: all outputs 0 immediately, busy=0; the next frame_start sends SOF WC 1. With CSI_PCKT_GEN_CRC_EN and payload bytes 31 32 33 34 ("1234"): CRC word 16'h???? taken from the bench's reference model (bench computes, not hardcoded).
